alu_wb_stage: RTL and testbench
===============================

# alu_wb_stage

Writeback stage directly downstream of the jacaranda-8 ALU. It queues ALU results in a small FIFO and retires them into the 4×8 general register file or the compare flag. Load writeback from memory has priority on the single register write port. The block also provides the two forwarded register read ports that feed the ALU `rd`/`rs` operands.

## Interface
- `DEPTH`, default 2: result FIFO depth; power of two, ≥2.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `vccd1`, `vssd1`  inout  1  power pins, present only under `USE_POWER_PINS`.
- `res_valid`  in  1  ALU result offered.
- `res_ready`  out  1  stage can accept a result.
- `res_data`  in  8  ALU output.
- `res_dst`  in  2  destination register index.
- `res_is_flag`  in  1  result is a compare (ALU op `4'b0111`); bit0 goes to the flag and no register is written.
- `mem_we`  in  1  load writeback this cycle.
- `mem_dst`  in  2  load destination register.
- `mem_data`  in  8  load data.
- `rd_addr`, `rs_addr`  in  2  read port addresses.
- `rd_data`, `rs_data`  out  8  forwarded read data, combinational.
- `flag`  out  1  forwarded compare flag.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Enqueue: occurs when `res_valid && res_ready`. The entry is {data, dst, is_flag}, written at the tail.
- `res_ready = (pending != DEPTH) && reset`. No combinational path from the drain to `res_ready`: a full FIFO refuses entry even in a cycle where it drains.
- Drain: when `pending != 0 && !mem_we`, the head retires.
  - If `is_flag`: `flag_q <= data[0]`.
  - Otherwise: `regs[dst] <= data`.
- Memory priority: when `mem_we` is high, `regs[mem_dst] <= mem_data` and the FIFO holds. A load is always older than any queued ALU result, so this priority preserves program order.
- Enqueue and drain in the same cycle: `pending` is unchanged and both pointers advance.
- Pointers wrap modulo `DEPTH`.
- Read forwarding, in priority order, per port:
  1. Youngest valid FIFO entry with `!is_flag` and matching dst.
  2. `mem_data`, if `mem_we` is high and `mem_dst` matches.
  3. `regs[addr]`.
- Flag forwarding: the youngest valid FIFO entry with `is_flag` supplies `data[0]`; otherwise `flag_q`.
- Register 0 is an ordinary writable register; it is not hardwired.
- Reset (`reset` low at a clock edge):
  - All registers become 0, `flag_q` becomes 0, and pointers and `pending` become 0.
  - Queued entries are discarded without being written.
  - Writes from `mem_we` in that cycle are ignored.
  - A handshake in the reset cycle is not accepted (`res_ready` is 0 while `reset` is low).
- Output reset values: `res_ready` 0 during reset and 1 after; `pending` 0; `rd_data`/`rs_data` 0; `flag` 0.

## Timing
- Enqueue-to-forward latency: 0 cycles after the accepting edge. The entry is visible on the read ports in the next cycle.
- Enqueue-to-architectural write: at least 1 cycle, extended by one cycle for every cycle `mem_we` is high.
- Throughput: one result per cycle while `mem_we` stays low.
- Sustained `mem_we` fills the FIFO after `DEPTH` accepts; `res_ready` then falls on the next cycle.
- Read ports and `flag` are purely combinational from state and from `mem_*` inputs.
- No combinational path from `res_*` inputs to any output.

## Structure
- Shared package `jacaranda_pkg` holds:
  - `DATA_W = 8`
  - `REG_ADDR_W = 2`
  - `NUM_REGS = 4`
  - `ALU_CEQ = 4'b0111`
  - the entry struct/width constant `WB_ENTRY_W = DATA_W + REG_ADDR_W + 1`
- Sub-module `wb_fifo`: a parameterised DEPTH-entry queue exposing all entries and their valid bits for forwarding, with head, tail and count.
- The top level contains the register file, flag, arbitration and forwarding muxes.

## Test plan
- Reset → all reads 0, `flag` 0, `pending` 0, `res_ready` 1 on the first cycle after reset is released.
- Accept {0x5A, r2} → `rd_data` (`rd_addr`=2) = 0x5A on the next cycle; `regs[2]` = 0x5A one edge later; `pending` returns to 0.
- `mem_we`=1 held for 3 cycles while 3 results are offered (DEPTH=2) → 2 accepted, `res_ready`=0 on the third; after `mem_we` drops, entries retire in order, one per cycle.
- Load r1=0x11 with queued ALU r1=0x22 → read of r1 shows 0x22 throughout; final `regs[1]` = 0x22.
- Compare result `res_data`=0x01 with `res_is_flag`=1 and `res_dst`=3 → `flag`=1 next cycle, `regs[3]` unchanged.
- Reset asserted with 2 entries pending → entries discarded, all regs 0, `pending` 0.

Source files
------------

// File: rtl/jacaranda_pkg.sv
// Shared jacaranda-8 widths and the writeback queue entry layout.
package jacaranda_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 4;

  localparam logic [3:0] ALU_CEQ = 4'b0111;

  localparam int WB_ENTRY_W = DATA_W + REG_ADDR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] dst;
    logic                  is_flag;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback result queue exposing every slot and its valid bit for forwarding.
// Latency: pushed entry visible on the outputs one edge after the push.
// Backpressure: caller must gate push with !full and pop with count != 0.
module wb_fifo
  import jacaranda_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  wb_entry_t                   push_dat,
  input  logic                        pop,
  output wb_entry_t [DEPTH-1:0]       entries,
  output logic      [DEPTH-1:0]       valid,
  output logic      [PTR_W-1:0]       head,
  output logic      [CNT_W-1:0]       count
);

  logic [PTR_W-1:0] tail;

  // Pointers are PTR_W bits wide, so wrap modulo DEPTH falls out of overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entries[tail] <= push_dat;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PTR_W'(PTR_W'(i) - head)} < count;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback: queues results, retires them to the 4x8 regfile or flag, forwards reads.
// Latency: queued result forwarded next cycle; retires >=1 cycle later, +1 per mem_we cycle.
// Backpressure: res_ready drops only when the queue is full; loads stall the drain.
module alu_wb_stage
  import jacaranda_pkg::*;
#(
  parameter int DEPTH = 2
) (
`ifdef USE_POWER_PINS
  inout  wire                         vccd1,
  inout  wire                         vssd1,
`endif
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [DATA_W-1:0]           res_data,
  input  logic [REG_ADDR_W-1:0]       res_dst,
  input  logic                        res_is_flag,
  input  logic                        mem_we,
  input  logic [REG_ADDR_W-1:0]       mem_dst,
  input  logic [DATA_W-1:0]           mem_data,
  input  logic [REG_ADDR_W-1:0]       rd_addr,
  input  logic [REG_ADDR_W-1:0]       rs_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [DATA_W-1:0]           rs_data,
  output logic                        flag,
  output logic [$clog2(DEPTH):0]      pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0]         regs [NUM_REGS];
  logic                      flag_q;

  wb_entry_t                 push_entry;
  wb_entry_t [DEPTH-1:0]     entries;
  wb_entry_t                 head_entry;
  logic      [DEPTH-1:0]     valid;
  logic      [PTR_W-1:0]     head;
  logic                      push;
  logic                      drain;

  // Full check uses registered occupancy only, so a draining full queue still refuses.
  assign res_ready  = (pending != CNT_W'(DEPTH)) && reset;
  assign push       = res_valid && res_ready;
  assign drain      = (pending != '0) && !mem_we;
  assign push_entry = {res_data, res_dst, res_is_flag};
  assign head_entry = entries[head];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (drain),
    .entries  (entries),
    .valid    (valid),
    .head     (head),
    .count    (pending)
  );

  // Loads win the single write port; they are always older than queued ALU results.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      flag_q <= 1'b0;
    end else if (mem_we) begin
      regs[mem_dst] <= mem_data;
    end else if (drain) begin
      if (head_entry.is_flag) begin
        flag_q <= head_entry.data[0];
      end else begin
        regs[head_entry.dst] <= head_entry.data;
      end
    end
  end

  logic                 rd_hit, rs_hit, fl_hit;
  logic [DATA_W-1:0]    rd_fwd, rs_fwd;
  logic                 fl_fwd;
  logic [PTR_W-1:0]     idx;
  wb_entry_t            ent;

  // Walk oldest to youngest so the youngest matching entry is the last to win.
  always_comb begin
    rd_hit = 1'b0;
    rs_hit = 1'b0;
    fl_hit = 1'b0;
    rd_fwd = '0;
    rs_fwd = '0;
    fl_fwd = 1'b0;
    idx    = '0;
    ent    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      ent = entries[idx];
      if (valid[idx]) begin
        if (ent.is_flag) begin
          fl_hit = 1'b1;
          fl_fwd = ent.data[0];
        end else begin
          if (ent.dst == rd_addr) begin
            rd_hit = 1'b1;
            rd_fwd = ent.data;
          end
          if (ent.dst == rs_addr) begin
            rs_hit = 1'b1;
            rs_fwd = ent.data;
          end
        end
      end
    end
  end

  assign rd_data = rd_hit ? rd_fwd :
                   (mem_we && (mem_dst == rd_addr)) ? mem_data : regs[rd_addr];
  assign rs_data = rs_hit ? rs_fwd :
                   (mem_we && (mem_dst == rs_addr)) ? mem_data : regs[rs_addr];
  assign flag    = fl_hit ? fl_fwd : flag_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: per-cycle expectations queued by stimulus, checked by a monitor.
module tb_alu_wb_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_dst;
  logic       res_is_flag;
  logic       mem_we;
  logic [1:0] mem_dst;
  logic [7:0] mem_data;
  logic [1:0] rd_addr;
  logic [1:0] rs_addr;
  logic [7:0] rd_data;
  logic [7:0] rs_data;
  logic       flag;
  logic [1:0] pending;

  alu_wb_stage #(.DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_dst     (res_dst),
    .res_is_flag (res_is_flag),
    .mem_we      (mem_we),
    .mem_dst     (mem_dst),
    .mem_data    (mem_data),
    .rd_addr     (rd_addr),
    .rs_addr     (rs_addr),
    .rd_data     (rd_data),
    .rs_data     (rs_data),
    .flag        (flag),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  // mask bits: 4 rd_data, 3 rs_data, 2 flag, 1 pending, 0 res_ready
  typedef struct {
    int         id;
    logic [4:0] m;
    logic [7:0] rd;
    logic [7:0] rs;
    logic       fl;
    logic [1:0] pd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   step_id = 0;

  task automatic drv(input logic rst, input logic rv, input logic [7:0] rdat,
                     input logic [1:0] rdst, input logic rflg, input logic mwe,
                     input logic [1:0] mdst, input logic [7:0] mdat,
                     input logic [1:0] ra, input logic [1:0] sa);
    reset = rst; res_valid = rv; res_data = rdat; res_dst = rdst; res_is_flag = rflg;
    mem_we = mwe; mem_dst = mdst; mem_data = mdat; rd_addr = ra; rs_addr = sa;
  endtask

  task automatic cyc(input logic [4:0] m, input logic [7:0] erd, input logic [7:0] ers,
                     input logic efl, input logic [1:0] epd, input logic erdy);
    exp_t e;
    e.id = step_id; e.m = m; e.rd = erd; e.rs = ers; e.fl = efl; e.pd = epd; e.rdy = erdy;
    q.push_back(e);
    step_id++;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[4]) begin
        n_vec++;
        if (rd_data !== e.rd) begin
          n_bad++;
          $display("FAIL step%0d rd_data got %h want %h", e.id, rd_data, e.rd);
        end
      end
      if (e.m[3]) begin
        n_vec++;
        if (rs_data !== e.rs) begin
          n_bad++;
          $display("FAIL step%0d rs_data got %h want %h", e.id, rs_data, e.rs);
        end
      end
      if (e.m[2]) begin
        n_vec++;
        if (flag !== e.fl) begin
          n_bad++;
          $display("FAIL step%0d flag got %b want %b", e.id, flag, e.fl);
        end
      end
      if (e.m[1]) begin
        n_vec++;
        if (pending !== e.pd) begin
          n_bad++;
          $display("FAIL step%0d pending got %0d want %0d", e.id, pending, e.pd);
        end
      end
      if (e.m[0]) begin
        n_vec++;
        if (res_ready !== e.rdy) begin
          n_bad++;
          $display("FAIL step%0d res_ready got %b want %b", e.id, res_ready, e.rdy);
        end
      end
    end
  end

  initial begin
    drv(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    @(posedge clock);
    #1;
    // 0: in reset, handshake refused
    drv(0, 1, 8'h12, 1, 0, 0, 0, 8'h00, 0, 0);      cyc(5'b00001, 8'h00, 8'h00, 0, 0, 0);
    // 1: out of reset
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 3);      cyc(5'b11111, 8'h00, 8'h00, 0, 0, 1);
    // 2-4: single result to r2
    drv(1, 1, 8'h5A, 2, 0, 0, 0, 8'h00, 2, 1);      cyc(5'b10011, 8'h00, 8'h00, 0, 0, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2, 2);      cyc(5'b11011, 8'h5A, 8'h5A, 0, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2, 0);      cyc(5'b11010, 8'h5A, 8'h00, 0, 0, 1);
    // 5-7: mem_we held, three offers, two accepted
    drv(1, 1, 8'h44, 1, 0, 1, 0, 8'h33, 0, 1);      cyc(5'b11011, 8'h33, 8'h00, 0, 0, 1);
    drv(1, 1, 8'h55, 3, 0, 1, 3, 8'h77, 1, 3);      cyc(5'b11011, 8'h44, 8'h77, 0, 1, 1);
    drv(1, 1, 8'h99, 0, 0, 1, 2, 8'h66, 3, 2);      cyc(5'b11011, 8'h55, 8'h66, 0, 2, 0);
    // 8-10: in-order retire, one per cycle
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 3);      cyc(5'b11011, 8'h44, 8'h55, 0, 2, 0);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 3);      cyc(5'b11011, 8'h44, 8'h55, 0, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0);      cyc(5'b11011, 8'h55, 8'h33, 0, 0, 1);
    // 11-14: queued ALU r1=0x22 beats younger-in-time load r1=0x11
    drv(1, 1, 8'h22, 1, 0, 0, 0, 8'h00, 1, 0);      cyc(5'b10010, 8'h44, 8'h00, 0, 0, 1);
    drv(1, 0, 8'h00, 0, 0, 1, 1, 8'h11, 1, 0);      cyc(5'b10010, 8'h22, 8'h00, 0, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);      cyc(5'b10010, 8'h22, 8'h00, 0, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);      cyc(5'b10010, 8'h22, 8'h00, 0, 0, 1);
    // 15-17: compare result to flag, r3 untouched
    drv(1, 1, 8'h01, 3, 1, 0, 0, 8'h00, 3, 0);      cyc(5'b10110, 8'h55, 8'h00, 0, 0, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0);      cyc(5'b10110, 8'h55, 8'h00, 1, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 3, 0);      cyc(5'b10110, 8'h55, 8'h00, 1, 0, 1);
    // 18-21: back-to-back accepts with simultaneous drain, pointer wrap, flag cleared
    drv(1, 1, 8'hA1, 0, 0, 0, 0, 8'h00, 0, 0);      cyc(5'b00011, 8'h00, 8'h00, 0, 0, 1);
    drv(1, 1, 8'h00, 2, 1, 0, 0, 8'h00, 0, 0);      cyc(5'b10111, 8'hA1, 8'h00, 1, 1, 1);
    drv(1, 1, 8'hB2, 0, 0, 0, 0, 8'h00, 0, 0);      cyc(5'b10111, 8'hA1, 8'h00, 0, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 2);      cyc(5'b11110, 8'hB2, 8'h66, 0, 1, 1);
    // 22-24: youngest of two same-dst entries wins
    drv(1, 1, 8'hC1, 2, 0, 1, 3, 8'h01, 2, 0);      cyc(5'b10010, 8'h66, 8'h00, 0, 0, 1);
    drv(1, 1, 8'hC2, 2, 0, 1, 3, 8'h02, 2, 0);      cyc(5'b10010, 8'hC1, 8'h00, 0, 1, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2, 3);      cyc(5'b11011, 8'hC2, 8'h02, 0, 2, 0);
    // 25-29: fill to two pending, reset discards them and ignores the load
    drv(1, 1, 8'hD1, 1, 0, 1, 0, 8'hEE, 2, 0);      cyc(5'b10011, 8'hC2, 8'h00, 0, 1, 1);
    drv(0, 1, 8'hD2, 3, 0, 1, 2, 8'hFF, 0, 0);      cyc(5'b00011, 8'h00, 8'h00, 0, 2, 0);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1);      cyc(5'b11111, 8'h00, 8'h00, 0, 0, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 2, 3);      cyc(5'b11111, 8'h00, 8'h00, 0, 0, 1);
    drv(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 2);      cyc(5'b11111, 8'h00, 8'h00, 0, 0, 1);

    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
